// File: rtl/softmax_normalizer.sv
// Normalizes ten fp32 exponentials by their fp32 sum with one shared restoring
// divider, and reports the index of the largest exponential.
module softmax_normalizer #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int DATA_WIDTH     = EXPONENT_WIDTH + MANTISSA_WIDTH + 1,
  parameter int NUM_CLASSES    = 10,
  parameter int IDX_WIDTH      = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [DATA_WIDTH*NUM_CLASSES-1:0] input_exps,
  input  logic [DATA_WIDTH-1:0]             input_sum,
  output logic [DATA_WIDTH*NUM_CLASSES-1:0] output_probs,
  output logic [IDX_WIDTH-1:0]              class_idx,
  output logic                              busy,
  output logic                              done_norm,
  output logic                              err,
  output logic [2:0]                        dbg_state
);

  // Handshake: start is a request accepted only in IDLE (busy low); inputs are
  // captured on that edge. done_norm pulses one cycle when results are valid,
  // on the same edge busy falls. Results hold until the next accepted start.

  localparam int EW     = EXPONENT_WIDTH;
  localparam int MW     = MANTISSA_WIDTH;
  localparam int DW     = DATA_WIDTH;
  localparam int MANT_W = MW + 1;
  localparam int REM_W  = MW + 3;
  localparam int E_W    = EW + 2;
  localparam int CNT_W  = $clog2(MANT_W);

  localparam logic [EW-1:0]           EXP_ONES = '1;
  localparam logic signed [E_W-1:0]   BIAS     = E_W'((1 << (EW - 1)) - 1);
  localparam logic signed [E_W-1:0]   E_MAX    = E_W'((1 << EW) - 1);
  localparam logic signed [E_W-1:0]   E_ZERO   = '0;
  localparam logic signed [E_W-1:0]   E_ONE    = E_W'(1);
  localparam logic [DW-1:0]           QNAN     = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(MANT_W - 1);
  localparam logic [IDX_WIDTH-1:0]    IDX_LAST = IDX_WIDTH'(NUM_CLASSES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_SETUP  = 3'd2,
    S_DIV    = 3'd3,
    S_WRITE  = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [DW*NUM_CLASSES-1:0] exps_q, exps_d;
  logic [DW-1:0]             sum_q, sum_d;
  logic [DW*NUM_CLASSES-1:0] probs_q, probs_d;
  logic [IDX_WIDTH-1:0]      idx_q, idx_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [IDX_WIDTH-1:0]      i_q, i_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [REM_W-1:0]          rem_q, rem_d;
  logic [MANT_W-1:0]         quo_q, quo_d;
  logic signed [E_W-1:0]     e_q, e_d;
  logic                      zero_q, zero_d;
  logic [DW-2:0]             max_q, max_d;

  logic [DW-1:0]         cur_exp;
  logic [MANT_W-1:0]     mb;
  logic [REM_W-1:0]      mb_ext;
  logic                  sum_bad;
  logic [MANT_W-1:0]     ma;
  logic signed [E_W-1:0] e_calc;
  logic [REM_W-1:0]      rem_sub;
  logic                  qbit;
  logic                  sign;
  logic [DW-1:0]         res;

  assign cur_exp = exps_q[DW*i_q +: DW];
  assign mb      = {1'b1, sum_q[MW-1:0]};
  assign mb_ext  = {2'b00, mb};
  assign sum_bad = (sum_q[DW-2 -: EW] == '0) || (sum_q[DW-2 -: EW] == EXP_ONES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_CHECK;
      S_CHECK:  state_d = sum_bad ? S_FINISH : S_SETUP;
      S_SETUP:  state_d = S_DIV;
      S_DIV:    if (cnt_q == CNT_LAST) state_d = S_WRITE;
      S_WRITE:  state_d = (i_q == IDX_LAST) ? S_FINISH : S_SETUP;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    exps_d  = exps_q;
    sum_d   = sum_q;
    probs_d = probs_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    i_d     = i_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    e_d     = e_q;
    zero_d  = zero_q;
    max_d   = max_q;
    ma      = {1'b1, cur_exp[MW-1:0]};
    e_calc  = $signed({2'b00, cur_exp[DW-2 -: EW]}) - $signed({2'b00, sum_q[DW-2 -: EW]}) + BIAS;
    rem_sub = rem_q;
    qbit    = 1'b0;
    sign    = cur_exp[DW-1] ^ sum_q[DW-1];
    res     = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          exps_d  = input_exps;
          sum_d   = input_sum;
          probs_d = '0;
          idx_d   = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_CHECK: begin
        i_d = '0;
        if (sum_bad) begin
          probs_d = {NUM_CLASSES{QNAN}};
          err_d   = 1'b1;
        end
      end
      S_SETUP: begin
        // Pre-normalize so the quotient lands in [1,2) and its MSB is set.
        if (ma < mb) begin
          rem_d = {1'b0, ma, 1'b0};
          e_d   = e_calc - E_ONE;
        end else begin
          rem_d = {2'b00, ma};
          e_d   = e_calc;
        end
        quo_d  = '0;
        cnt_d  = '0;
        zero_d = (cur_exp[DW-2 -: EW] == '0);
      end
      S_DIV: begin
        if (rem_q >= mb_ext) begin
          rem_sub = rem_q - mb_ext;
          qbit    = 1'b1;
        end
        rem_d = rem_sub << 1;
        quo_d = (quo_q << 1) | MANT_W'(qbit);
        cnt_d = cnt_q + 1'b1;
      end
      S_WRITE: begin
        if (zero_q)              res = '0;
        else if (e_q <= E_ZERO)  res = '0;
        else if (e_q >= E_MAX)   res = {sign, EXP_ONES, {MW{1'b0}}};
        else                     res = {sign, e_q[EW-1:0], quo_q[MW-1:0]};
        probs_d[DW*i_q +: DW] = res;
        // Strictly-greater keeps the lowest index on ties.
        if ((i_q == '0) || (cur_exp[DW-2:0] > max_q)) begin
          max_d = cur_exp[DW-2:0];
          idx_d = i_q;
        end
        i_d = i_q + 1'b1;
      end
      S_FINISH: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exps_q  <= '0;
      sum_q   <= '0;
      probs_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      i_q     <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      e_q     <= '0;
      zero_q  <= 1'b0;
      max_q   <= '0;
    end else begin
      exps_q  <= exps_d;
      sum_q   <= sum_d;
      probs_q <= probs_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      i_q     <= i_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      e_q     <= e_d;
      zero_q  <= zero_d;
      max_q   <= max_d;
    end
  end

  assign output_probs = probs_q;
  assign class_idx    = idx_q;
  assign busy         = busy_q;
  assign done_norm    = done_q;
  assign err          = err_q;
  assign dbg_state    = state_q;

endmodule
